// File: rtl/cpu_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_trace_pkg: shared constants, state encoding, nibble-to-ASCII      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_trace_pkg;

  localparam logic [7:0] CARET  = 8'h5e;
  localparam logic [7:0] AT     = 8'h40;
  localparam logic [7:0] COLON  = 8'h3a;
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] STAR   = 8'h2a;
  localparam logic [7:0] LT     = 8'h3c;
  localparam logic [7:0] EQ     = 8'h3d;
  localparam logic [7:0] HASH   = 8'h23;

  localparam logic [1:0] REC_REG = 2'b01;
  localparam logic [1:0] REC_MEM = 2'b10;

  localparam logic [13:0] TIME_MAX    = 14'd9999;
  localparam logic [3:0]  CONV_CYCLES = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Lowercase hex digit.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq: 14-bit sequential double-dabble, one shift per cycle     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bin2bcd_seq
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [15:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= CONV_CYCLES;
    end else if (r_cnt != 4'd0) begin
      r_bcd <= {w_adj[14:0], r_bin[13]};
      r_bin <= {r_bin[12:0], 1'b0};
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // High during the final shift cycle, so bcd is complete from the next cycle.
  assign done = (r_cnt == 4'd1);
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/cpu_trace_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_trace_emitter: serialises register/memory trace records as ASCII  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_trace_emitter
  import cpu_trace_pkg::*;
#(
  parameter int COLON_SPACES  = 1,
  parameter int ASSIGN_SPACES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  char,
  output logic        busy,
  output logic        time_sat
);

  state_t      r_state;
  logic [31:0] r_pc, r_addr, r_data;
  logic [4:0]  r_grf;
  logic        r_is_mem;
  logic [5:0]  r_idx;
  logic [7:0]  r_char;
  logic        r_out_valid, r_busy, r_time_sat;

  logic        w_accept, w_bcd_done;
  logic [13:0] w_time;
  logic [15:0] w_bcd;
  logic [2:0]  w_td;
  logic [1:0]  w_gd, w_tens;
  logic [3:0]  w_ones;
  logic [5:0]  w_fl, w_idx;
  logic [5:0]  w_p_at, w_p_colon, w_p_tag, w_p_sp, w_p_eq, w_p_data, w_p_hash;
  logic [7:0]  w_next_char;

  function automatic logic [3:0] bcd_nib(input logic [15:0] b, input logic [1:0] sel);
    return b[{sel, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] word_nib(input logic [31:0] w, input logic [2:0] k);
    return w[{3'd7 - k, 2'b00} +: 4];
  endfunction

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_time   = (in_time > TIME_MAX) ? TIME_MAX : in_time;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_accept),
    .bin   (w_time),
    .done  (w_bcd_done),
    .bcd   (w_bcd)
  );

  always_comb begin
    if      (w_bcd[15:12] != 4'd0) w_td = 3'd4;
    else if (w_bcd[11:8]  != 4'd0) w_td = 3'd3;
    else if (w_bcd[7:4]   != 4'd0) w_td = 3'd2;
    else                           w_td = 3'd1;
  end

  assign w_tens = (r_grf >= 5'd30) ? 2'd3 : (r_grf >= 5'd20) ? 2'd2 :
                  (r_grf >= 5'd10) ? 2'd1 : 2'd0;
  assign w_ones = 4'(r_grf - 5'(w_tens) * 5'd10);
  assign w_gd   = (r_grf >= 5'd10) ? 2'd2 : 2'd1;
  assign w_fl   = r_is_mem ? 6'd8 : 6'(w_gd);

  // Start position of every field inside the string.
  assign w_p_at    = 6'(w_td) + 6'd1;
  assign w_p_colon = w_p_at + 6'd9;
  assign w_p_tag   = w_p_colon + 6'(COLON_SPACES) + 6'd1;
  assign w_p_sp    = w_p_tag + w_fl + 6'd1;
  assign w_p_eq    = w_p_sp + 6'd2;
  assign w_p_data  = w_p_eq + 6'(ASSIGN_SPACES) + 6'd1;
  assign w_p_hash  = w_p_data + 6'd8;

  assign w_idx = r_idx + 6'd1;

  // Character for the index after the one currently presented.
  always_comb begin
    w_next_char = HASH;
    if (w_idx <= 6'(w_td))
      w_next_char = nib2ascii(bcd_nib(w_bcd, 2'(6'(w_td) - w_idx)));
    else if (w_idx == w_p_at)
      w_next_char = AT;
    else if (w_idx < w_p_colon)
      w_next_char = nib2ascii(word_nib(r_pc, 3'(w_idx - w_p_at - 6'd1)));
    else if (w_idx == w_p_colon)
      w_next_char = COLON;
    else if (w_idx < w_p_tag)
      w_next_char = SPACE;
    else if (w_idx == w_p_tag)
      w_next_char = r_is_mem ? STAR : DOLLAR;
    else if (w_idx < w_p_sp) begin
      if (r_is_mem)
        w_next_char = nib2ascii(word_nib(r_addr, 3'(w_idx - w_p_tag - 6'd1)));
      else if (w_gd == 2'd2 && w_idx == w_p_tag + 6'd1)
        w_next_char = nib2ascii({2'b00, w_tens});
      else
        w_next_char = nib2ascii(w_ones);
    end
    else if (w_idx == w_p_sp)
      w_next_char = SPACE;
    else if (w_idx == w_p_sp + 6'd1)
      w_next_char = LT;
    else if (w_idx == w_p_eq)
      w_next_char = EQ;
    else if (w_idx < w_p_data)
      w_next_char = SPACE;
    else if (w_idx < w_p_hash)
      w_next_char = nib2ascii(word_nib(r_data, 3'(w_idx - w_p_data)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_grf       <= '0;
      r_is_mem    <= 1'b0;
      r_idx       <= '0;
      r_char      <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_time_sat  <= 1'b0;
    end else begin
      r_time_sat <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_pc       <= in_pc;
            r_addr     <= in_addr;
            r_data     <= in_data;
            r_grf      <= in_grf;
            r_is_mem   <= (in_type == REC_MEM);
            r_time_sat <= (in_time > TIME_MAX);
            r_busy     <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          if (w_bcd_done) begin
            r_idx       <= '0;
            r_char      <= CARET;
            r_out_valid <= 1'b1;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_idx == w_p_hash) begin
              r_idx       <= '0;
              r_char      <= 8'h00;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_idx  <= w_idx;
              r_char <= w_next_char;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign char      = r_char;
  assign busy      = r_busy;
  assign time_sat  = r_time_sat;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_emitter.sv
`default_nettype none
// Self-checking bench: directed and random records compared with a string-level model.
module tb_cpu_trace_emitter;

  localparam int CS = 1;
  localparam int AS = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_type = 2'b01;
  logic [13:0] in_time = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_grf = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  ch;
  logic        busy;
  logic        time_sat;

  int checks = 0;
  int failures = 0;

  cpu_trace_emitter #(.COLON_SPACES(CS), .ASSIGN_SPACES(AS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_time   (in_time),
    .in_pc     (in_pc),
    .in_grf    (in_grf),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .char      (ch),
    .busy      (busy),
    .time_sat  (time_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected string built directly from the trace grammar.
  function automatic string model(input logic [1:0] ty, input int tm, input logic [31:0] pc,
                                  input int grf, input logic [31:0] addr, input logic [31:0] data);
    string s;
    int t;
    t = (tm > 9999) ? 9999 : tm;
    s = $sformatf("^%0d@%08h:", t, pc);
    for (int i = 0; i < CS; i++) s = {s, " "};
    if (ty == 2'b10) s = {s, $sformatf("*%08h", addr)};
    else             s = {s, $sformatf("$%0d", grf)};
    s = {s, " <="};
    for (int i = 0; i < AS; i++) s = {s, " "};
    s = {s, $sformatf("%08h#", data)};
    return s;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic accept(input logic [1:0] ty, input int tm, input logic [31:0] pc,
                        input int grf, input logic [31:0] addr, input logic [31:0] data);
    chk("in_ready_before_accept", in_ready, 1);
    in_type = ty; in_time = 14'(tm); in_pc = pc; in_grf = 5'(grf);
    in_addr = addr; in_data = data; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("time_sat_on_accept", time_sat, (tm > 9999) ? 1 : 0);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic receive(input string exp, input bit bp, input int abort_n, input string tag);
    int cyc, idx, n, len;
    bit stalled, r;
    logic [7:0] held;
    len = exp.len();
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk("time_sat_single_pulse", time_sat, 0);
    end
    chk({tag, "_first_char_latency"}, cyc, 15);
    idx = 0; n = 0; stalled = 0; held = 8'h00;
    while (idx < len && n < 600) begin
      chk({tag, "_out_valid"}, out_valid, 1);
      if (stalled) chk({tag, "_stable_char"}, ch, held);
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (r) begin
        chk($sformatf("%s_char%0d", tag, idx), ch, 8'(exp[idx]));
        idx++;
        stalled = 0;
        if (idx == abort_n) return;
      end else begin
        stalled = 1;
        held = ch;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    chk({tag, "_all_chars_emitted"}, idx, len);
    if (!bp) chk({tag, "_contiguous"}, n, len);
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_char"}, ch, 8'h00);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    string e1;
    int vcount;
    logic [1:0] rty;
    int rtm, rgrf;
    logic [31:0] rpc, raddr, rdata;

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_char", ch, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_time_sat", time_sat, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Register record
    e1 = model(2'b01, 12, 32'h00003004, 5, 0, 32'hdeadbeef);
    chk("s1_model_len", e1.len(), 29);
    accept(2'b01, 12, 32'h00003004, 5, 32'h0, 32'hdeadbeef);
    receive(e1, 1'b0, -1, "s1");

    // Memory record
    accept(2'b10, 0, 32'h00003ffc, 0, 32'h00002ffc, 32'h0);
    receive(model(2'b10, 0, 32'h00003ffc, 0, 32'h00002ffc, 32'h0), 1'b0, -1, "s2");

    // Boundaries
    accept(2'b01, 9999, 32'h12345678, 31, 32'h0, 32'h9abcdef0);
    receive(model(2'b01, 9999, 32'h12345678, 31, 0, 32'h9abcdef0), 1'b0, -1, "s3max");
    accept(2'b01, 10000, 32'hcafef00d, 10, 32'h0, 32'h00000001);
    receive(model(2'b01, 10000, 32'hcafef00d, 10, 0, 32'h00000001), 1'b0, -1, "s3sat");

    // Back-pressure
    accept(2'b01, 12, 32'h00003004, 5, 32'h0, 32'hdeadbeef);
    receive(e1, 1'b1, -1, "s4");

    // Busy protection: a different record stays offered throughout
    accept(2'b01, 12, 32'h00003004, 5, 32'h0, 32'hdeadbeef);
    in_type = 2'b10; in_time = 14'd77; in_pc = 32'h0badc0de; in_grf = 5'd3;
    in_addr = 32'h00abcdef; in_data = 32'h13579bdf; in_valid = 1'b1;
    receive(e1, 1'b0, -1, "s6a");
    @(negedge clk);
    in_valid = 1'b0;
    chk("s6_second_accepted", busy, 1);
    receive(model(2'b10, 77, 32'h0badc0de, 3, 32'h00abcdef, 32'h13579bdf), 1'b0, -1, "s6b");

    // Asynchronous reset mid-record
    accept(2'b01, 12, 32'h00003004, 5, 32'h0, 32'hdeadbeef);
    receive(e1, 1'b0, 10, "s5");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("s5_async_valid", out_valid, 0);
    chk("s5_async_char", ch, 8'h00);
    chk("s5_async_busy", busy, 0);
    chk("s5_async_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) vcount++;
    end
    chk("s5_no_trailing_chars", vcount, 0);
    chk("s5_ready_after_release", in_ready, 1);
    accept(2'b10, 4321, 32'h00400000, 0, 32'hfffffffc, 32'h89abcdef);
    receive(model(2'b10, 4321, 32'h00400000, 0, 32'hfffffffc, 32'h89abcdef), 1'b0, -1, "s5fresh");

    // Random records
    for (int t = 0; t < 10; t++) begin
      rty = 2'($urandom_range(0, 3));
      rtm = (t == 0) ? 0 : int'($urandom_range(0, 16383));
      rgrf = int'($urandom_range(0, 31));
      rpc = $urandom; raddr = $urandom; rdata = $urandom;
      accept(rty, rtm, rpc, rgrf, raddr, rdata);
      receive(model(rty, rtm, rpc, rgrf, raddr, rdata), 1'($urandom_range(0, 1)), -1,
              $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
